// File: rtl/prog_loader.sv
// Assembles a checksummed byte frame into 16-bit words and writes them to instruction RAM; holds the CPU until a good load.
// Latency: each word is written 1 cycle after its LO byte. No backpressure: every rx_valid byte is consumed.
module prog_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          MAX_WORDS = 1024,
   parameter int          TIMEOUT   = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [15:0] instr_wr_addr,
   output logic [15:0] instr_wr_data,
   output logic        instr_wen,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   localparam int             TW       = $clog2(TIMEOUT + 1);
   localparam logic [16:0]    MAX_LEN  = 17'(MAX_WORDS);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    checksum, checksum_nxt;
   logic [7:0]    hi_q, hi_nxt;
   logic [15:0]   len_q, len_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [15:0]   wr_addr_nxt, wr_data_nxt, words_nxt;
   logic          wen_nxt, hold_nxt, busy_nxt, done_nxt, error_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cpu_hold      <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         instr_wen     <= 1'b0;
         instr_wr_addr <= 16'h0000;
         instr_wr_data <= 16'h0000;
         words_loaded  <= 16'h0000;
         checksum      <= 8'h00;
         timer         <= '0;
         hi_q          <= 8'h00;
         len_q         <= 16'h0000;
      end else begin
         state         <= state_nxt;
         cpu_hold      <= hold_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         error         <= error_nxt;
         instr_wen     <= wen_nxt;
         instr_wr_addr <= wr_addr_nxt;
         instr_wr_data <= wr_data_nxt;
         words_loaded  <= words_nxt;
         checksum      <= checksum_nxt;
         timer         <= timer_nxt;
         hi_q          <= hi_nxt;
         len_q         <= len_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_nxt     = cpu_hold;
      busy_nxt     = busy;
      done_nxt     = done;
      error_nxt    = error;
      wen_nxt      = 1'b0;
      wr_addr_nxt  = instr_wr_addr;
      wr_data_nxt  = instr_wr_data;
      words_nxt    = words_loaded;
      checksum_nxt = checksum;
      timer_nxt    = timer;
      hi_nxt       = hi_q;
      len_nxt      = len_q;

      case (state)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_nxt    = LEN_HI;
               done_nxt     = 1'b0;
               error_nxt    = 1'b0;
               words_nxt    = 16'h0000;
               checksum_nxt = 8'h00;
               timer_nxt    = '0;
               busy_nxt     = 1'b1;
               hold_nxt     = 1'b1;
            end
         end
         default: begin
            if (rx_valid) begin
               timer_nxt = '0;
               if (state != CHECK) checksum_nxt = checksum ^ rx_data;
               case (state)
                  LEN_HI: begin
                     hi_nxt    = rx_data;
                     state_nxt = LEN_LO;
                  end
                  LEN_LO: begin
                     len_nxt = {hi_q, rx_data};
                     if ({1'b0, hi_q, rx_data} > MAX_LEN) begin
                        state_nxt = ERR;
                        error_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                     end else if ({hi_q, rx_data} == 16'h0000) begin
                        state_nxt = CHECK;
                     end else begin
                        state_nxt = DATA_HI;
                     end
                  end
                  DATA_HI: begin
                     hi_nxt    = rx_data;
                     state_nxt = DATA_LO;
                  end
                  DATA_LO: begin
                     wen_nxt     = 1'b1;
                     wr_addr_nxt = BASE_ADDR + words_loaded;
                     wr_data_nxt = {hi_q, rx_data};
                     words_nxt   = words_loaded + 16'd1;
                     state_nxt   = (words_nxt == len_q) ? CHECK : DATA_HI;
                  end
                  CHECK: begin
                     busy_nxt = 1'b0;
                     if (rx_data == checksum) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        hold_nxt  = 1'b0;
                     end else begin
                        state_nxt = ERR;
                        error_nxt = 1'b1;
                     end
                  end
                  default: state_nxt = IDLE;
               endcase
            end else if (timer == TMO_LAST) begin
               // The TIMEOUT-th silent cycle aborts the load.
               state_nxt = ERR;
               error_nxt = 1'b1;
               busy_nxt  = 1'b0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
      endcase
   end

endmodule
